// File: rtl/decode_pkg.sv
// Shared constants, control-field layout and main-control decode for the ID stage.
package decode_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned OPC_W    = 6;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;

  // Bit positions inside the wb / m / ex control groups
  localparam int unsigned WB_REG_WRITE = 1;
  localparam int unsigned WB_MEM_TO_REG = 0;
  localparam int unsigned M_BRANCH     = 2;
  localparam int unsigned M_MEM_READ   = 1;
  localparam int unsigned M_MEM_WRITE  = 0;
  localparam int unsigned EX_REG_DST   = 3;
  localparam int unsigned EX_ALU_OP_HI = 2;
  localparam int unsigned EX_ALU_OP_LO = 1;
  localparam int unsigned EX_ALU_SRC   = 0;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] m;
    logic [3:0] ex;
  } ctrl_t;

  // Unknown opcodes fall through as an all-zero NOP.
  function automatic ctrl_t decode_ctrl(input logic [OPC_W-1:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.wb[WB_REG_WRITE]                 = 1'b1;
        c.ex[EX_REG_DST]                   = 1'b1;
        c.ex[EX_ALU_OP_HI:EX_ALU_OP_LO]    = ALU_FUNCT;
      end
      OP_LW: begin
        c.wb[WB_REG_WRITE]                 = 1'b1;
        c.wb[WB_MEM_TO_REG]                = 1'b1;
        c.m[M_MEM_READ]                    = 1'b1;
        c.ex[EX_ALU_OP_HI:EX_ALU_OP_LO]    = ALU_ADD;
        c.ex[EX_ALU_SRC]                   = 1'b1;
      end
      OP_SW: begin
        c.m[M_MEM_WRITE]                   = 1'b1;
        c.ex[EX_ALU_OP_HI:EX_ALU_OP_LO]    = ALU_ADD;
        c.ex[EX_ALU_SRC]                   = 1'b1;
      end
      OP_BEQ: begin
        c.m[M_BRANCH]                      = 1'b1;
        c.ex[EX_ALU_OP_HI:EX_ALU_OP_LO]    = ALU_SUB;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32x32 register file: two combinational read ports with write-through bypass, one sync write port.
module regFile
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  raddr1,
  input  logic [REG_W-1:0]  raddr2,
  input  logic              we,
  input  logic [REG_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata1_c,
  output logic [DATA_W-1:0] rdata2_c
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_en_c;

  assign wr_en_c = we && (waddr != '0);

  // Reset clears every entry and wins over a concurrent writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (wr_en_c) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1_c = regs[raddr1];
    rdata2_c = regs[raddr2];
    if (wr_en_c && (waddr == raddr1)) rdata1_c = wdata;
    if (wr_en_c && (waddr == raddr2)) rdata2_c = wdata;
    if (raddr1 == '0) rdata1_c = '0;
    if (raddr2 == '0) rdata2_c = '0;
  end

endmodule

// File: rtl/decode.sv
// MIPS instruction-decode stage: register read, sign extension, main control and the ID/EX latch.
module decode
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] if_id_npc,
  input  logic [DATA_W-1:0] if_id_instr,
  input  logic              id_flush,
  input  logic              mem_wb_reg_write,
  input  logic [REG_W-1:0]  mem_wb_write_reg,
  input  logic [DATA_W-1:0] mem_wb_write_data,
  output logic [1:0]        id_ex_wb,
  output logic [2:0]        id_ex_m,
  output logic [3:0]        id_ex_ex,
  output logic [DATA_W-1:0] id_ex_npc,
  output logic [DATA_W-1:0] id_ex_rd1,
  output logic [DATA_W-1:0] id_ex_rd2,
  output logic [DATA_W-1:0] id_ex_sign_ext,
  output logic [REG_W-1:0]  id_ex_rt,
  output logic [REG_W-1:0]  id_ex_rd
);

  logic [DATA_W-1:0] rd1_c;
  logic [DATA_W-1:0] rd2_c;
  logic [DATA_W-1:0] sign_ext_c;
  ctrl_t             ctrl_c;

  regFile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .raddr1   (if_id_instr[25:21]),
    .raddr2   (if_id_instr[20:16]),
    .we       (mem_wb_reg_write),
    .waddr    (mem_wb_write_reg),
    .wdata    (mem_wb_write_data),
    .rdata1_c (rd1_c),
    .rdata2_c (rd2_c)
  );

  // Offsets stay in words to match fetch's +1 PC, so no shift here.
  assign sign_ext_c = {{16{if_id_instr[15]}}, if_id_instr[15:0]};

  always_comb begin
    ctrl_c = '0;
    if (!id_flush) ctrl_c = decode_ctrl(if_id_instr[31:26]);
  end

  // ID/EX latch loads every cycle; flush only bubbles the control groups.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_wb       <= '0;
      id_ex_m        <= '0;
      id_ex_ex       <= '0;
      id_ex_npc      <= '0;
      id_ex_rd1      <= '0;
      id_ex_rd2      <= '0;
      id_ex_sign_ext <= '0;
      id_ex_rt       <= '0;
      id_ex_rd       <= '0;
    end else begin
      id_ex_wb       <= ctrl_c.wb;
      id_ex_m        <= ctrl_c.m;
      id_ex_ex       <= ctrl_c.ex;
      id_ex_npc      <= if_id_npc;
      id_ex_rd1      <= rd1_c;
      id_ex_rd2      <= rd2_c;
      id_ex_sign_ext <= sign_ext_c;
      id_ex_rt       <= if_id_instr[20:16];
      id_ex_rd       <= if_id_instr[15:11];
    end
  end

endmodule

// File: doc/decode.md
# decode

Instruction-decode stage of the five-stage MIPS pipeline, directly downstream of `fetch`. It consumes the IF/ID latch outputs (next-PC and instruction), reads the 32×32 register file, sign-extends the immediate, and generates main control. The results are registered into the ID/EX pipeline latch. The stage also owns the register-file write port, driven by the MEM/WB writeback bus.

## Interface
- No parameters; widths fixed (32-bit datapath, 5-bit register index, word-addressed PC).
- `clk` input 1: sole clock; all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `if_id_npc` input 32: PC+1 from IF/ID latch.
- `if_id_instr` input 32: instruction from IF/ID latch.
- `id_flush` input 1: when high, the latched control fields are forced to zero (bubble).
- `mem_wb_reg_write` input 1: writeback enable.
- `mem_wb_write_reg` input 5: writeback destination register.
- `mem_wb_write_data` input 32: writeback data.
- `id_ex_wb` output 2: {RegWrite, MemtoReg}.
- `id_ex_m` output 3: {Branch, MemRead, MemWrite}.
- `id_ex_ex` output 4: {RegDst, ALUOp[1:0], ALUSrc}.
- `id_ex_npc` output 32: latched `if_id_npc`.
- `id_ex_rd1` / `id_ex_rd2` output 32: register data for rs / rt.
- `id_ex_sign_ext` output 32: sign-extended instr[15:0].
- `id_ex_rt` / `id_ex_rd` output 5: instr[20:16] / instr[15:11].

## Operation
- Register read is combinational on rs = instr[25:21] and rt = instr[20:16]. Register $0 always reads 0.
- Register write happens at posedge when `mem_wb_reg_write`=1 and `mem_wb_write_reg`≠0. Writes to $0 are dropped.
- Write-through bypass: if the same cycle writes register r≠0 and reads r, the read returns `mem_wb_write_data`.
- Sign extension: {{16{instr[15]}}, instr[15:0]}. There is no shift; branch offsets are in words, matching fetch's +1 PC.
- Control decode on opcode instr[31:26]. Fields are listed as ex / m / wb:
  - R-type 000000: 1100 / 000 / 10.
  - lw 100011: 0001 / 010 / 11.
  - sw 101011: 0001 / 001 / 00.
  - beq 000100: 0010 / 100 / 00.
  - Any other opcode: all-zero control (NOP).
- `id_flush`=1 zeroes `id_ex_wb`, `id_ex_m`, and `id_ex_ex` at the next edge. Data fields are still latched normally. Writeback is unaffected.

## Timing
- Latency is 1 cycle. Inputs valid before posedge n appear on all `id_ex_*` outputs after posedge n.
- There are no stalls or handshake; the latch loads every cycle.
- Reset priority is `rst` > flush > normal load.
- On any posedge with `rst`=1:
  - All `id_ex_*` outputs go to 0.
  - All 32 registers clear to 0.
  - Any concurrent writeback is discarded.
- Reset mid-operation behaves identically; there is no partial state.
- The all-zero instruction (fetch's reset output) decodes as R-type writing $0. This is harmless and is required to produce wb=10 and ex=1100.
- Simultaneous flush and writeback: the register write completes and the controls latch as zero.

## Structure
- Shared package/header holds:
  - Opcode constants (R-type, lw, sw, beq).
  - Bit positions of the wb/m/ex control fields.
  - ALUOp encodings (00 add, 01 sub, 10 funct).
- One sub-module, `regFile`, containing:
  - 32×32 storage.
  - Two combinational read ports with bypass.
  - One sync write port.
  - Sync reset.
- Control decode, sign extension, and the ID/EX latch live in `decode`.

## Test plan
- Reset: hold `rst` for 2 cycles with arbitrary inputs. All `id_ex_*` = 0. After release, reading $5 gives 0.
- Write then read:
  - Stimulus: write $8 = 0xDEADBEEF. Next cycle, instr 0x01084820 (add $9,$8,$8), npc = 7.
  - Required: rd1 = rd2 = 0xDEADBEEF, ex = 1100, m = 000, wb = 10, rd = 9, npc = 7.
- Same-cycle bypass:
  - Stimulus: write $3 = 0x1234 while instr 0x8C64FFFC (lw $4,-4($3)) is presented.
  - Required: rd1 = 0x1234, sign_ext = 0xFFFFFFFC, rt = 4, ex = 0001, m = 010, wb = 11.
- $0 protection: write $0 = 0xFFFFFFFF with a concurrent read of $0. rd1 = 0; a later read of $0 also gives 0.
- Flush and unknown opcode:
  - beq 0x1085000A with `id_flush`=1 gives all controls 0 and sign_ext = 0x0000000A.
  - Opcode 111111 with no flush gives all controls 0.
- Reset during writeback: `rst`=1 concurrent with a write of $10 = 0x55. After the edge, $10 reads 0.
